// File: rtl/wb_data_resize_seq.sv
// wb_data_resize_seq: splits 32-bit Wishbone master accesses into sequential 8-bit slave cycles.
// Optional per-byte slave timeout is enabled with the WB_RESIZE_TIMEOUT_EN macro.
module wb_data_resize_seq #(
    parameter int aw      = 32,
    parameter     endian  = "big",
    parameter int TIMEOUT = 255
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_ni,
    input  logic [aw-1:0] wbm_adr_i,
    input  logic [31:0]   wbm_dat_i,
    input  logic [3:0]    wbm_sel_i,
    input  logic          wbm_we_i,
    input  logic          wbm_cyc_i,
    input  logic          wbm_stb_i,
    input  logic [2:0]    wbm_cti_i,
    input  logic [1:0]    wbm_bte_i,
    output logic [31:0]   wbm_dat_o,
    output logic          wbm_ack_o,
    output logic          wbm_err_o,
    output logic          wbm_rty_o,
    output logic [aw-1:0] wbs_adr_o,
    output logic [7:0]    wbs_dat_o,
    output logic          wbs_we_o,
    output logic          wbs_cyc_o,
    output logic          wbs_stb_o,
    output logic [2:0]    wbs_cti_o,
    output logic [1:0]    wbs_bte_o,
    input  logic [7:0]    wbs_dat_i,
    input  logic          wbs_ack_i,
    input  logic          wbs_err_i,
    input  logic          wbs_rty_i
);
    localparam bit BIG = (endian == "big");

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    state_t        r_state;
    logic [aw-3:0] r_adr;
    logic [31:0]   r_dat;
    logic [31:0]   r_rd;
    logic [3:0]    r_mask;
    logic          r_we;
    logic [1:0]    w_lane;
    logic [1:0]    w_nlane;
    logic [1:0]    w_flane;
    logic [3:0]    w_mask_nx;
    logic [31:0]   w_rd_nx;
    logic          w_to;
    logic          w_unused;

    // Pending lane with the lowest byte address for the configured endianness
    function automatic logic [1:0] f_lane(input logic [3:0] m);
        if (BIG) return m[3] ? 2'd3 : m[2] ? 2'd2 : m[1] ? 2'd1 : 2'd0;
        return m[0] ? 2'd0 : m[1] ? 2'd1 : m[2] ? 2'd2 : 2'd3;
    endfunction

    function automatic logic [1:0] f_addr(input logic [1:0] l);
        return BIG ? ~l : l;
    endfunction

    assign w_lane    = f_lane(r_mask);
    assign w_mask_nx = r_mask & ~(4'b0001 << w_lane);
    assign w_nlane   = f_lane(w_mask_nx);
    assign w_flane   = f_lane(wbm_sel_i);
    assign wbs_cti_o = 3'b000;
    assign wbs_bte_o = 2'b00;
    assign w_unused  = ^{wbm_cti_i, wbm_bte_i, wbm_adr_i[1:0], 1'(TIMEOUT)};

    always_comb begin
        w_rd_nx = r_rd;
        if (!r_we) w_rd_nx[8*w_lane +: 8] = wbs_dat_i;
    end

`ifdef WB_RESIZE_TIMEOUT_EN
    localparam int CW = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
    logic [CW-1:0] r_cnt;
    assign w_to = (r_cnt == CW'(TIMEOUT - 1));
    // Restarts on entry to BUS and on every acked byte
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
        if (!wb_rst_ni) r_cnt <= '0;
        else r_cnt <= (r_state == BUS && !wbs_ack_i) ? r_cnt + 1'b1 : '0;
`else
    assign w_to = 1'b0;
`endif

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state   <= IDLE;
            r_adr     <= '0;
            r_dat     <= '0;
            r_rd      <= '0;
            r_mask    <= '0;
            r_we      <= 1'b0;
            wbm_dat_o <= '0;
            wbm_ack_o <= 1'b0;
            wbm_err_o <= 1'b0;
            wbm_rty_o <= 1'b0;
            wbs_adr_o <= '0;
            wbs_dat_o <= '0;
            wbs_we_o  <= 1'b0;
            wbs_cyc_o <= 1'b0;
            wbs_stb_o <= 1'b0;
        end else begin
            wbm_ack_o <= 1'b0;
            wbm_err_o <= 1'b0;
            wbm_rty_o <= 1'b0;
            case (r_state)
                IDLE: if (wbm_cyc_i && wbm_stb_i) begin
                    r_adr  <= wbm_adr_i[aw-1:2];
                    r_dat  <= wbm_dat_i;
                    r_we   <= wbm_we_i;
                    r_mask <= wbm_sel_i;
                    r_rd   <= '0;
                    if (wbm_sel_i == 4'b0000) begin
                        r_state   <= RESP;
                        wbm_ack_o <= 1'b1;
                        wbm_dat_o <= '0;
                    end else begin
                        r_state   <= BUS;
                        wbs_cyc_o <= 1'b1;
                        wbs_stb_o <= 1'b1;
                        wbs_we_o  <= wbm_we_i;
                        wbs_adr_o <= {wbm_adr_i[aw-1:2], f_addr(w_flane)};
                        wbs_dat_o <= wbm_dat_i[8*w_flane +: 8];
                    end
                end
                BUS: if (!wbm_cyc_i) begin
                    r_state   <= IDLE;
                    wbs_cyc_o <= 1'b0;
                    wbs_stb_o <= 1'b0;
                    wbs_we_o  <= 1'b0;
                end else if (wbs_err_i || wbs_rty_i || w_to) begin
                    r_state   <= RESP;
                    wbs_cyc_o <= 1'b0;
                    wbs_stb_o <= 1'b0;
                    wbs_we_o  <= 1'b0;
                    wbm_err_o <= wbs_err_i || !wbs_rty_i;
                    wbm_rty_o <= wbs_rty_i && !wbs_err_i;
                    wbm_dat_o <= r_rd;
                end else if (wbs_ack_i) begin
                    r_rd   <= w_rd_nx;
                    r_mask <= w_mask_nx;
                    if (w_mask_nx == 4'b0000) begin
                        r_state   <= RESP;
                        wbs_cyc_o <= 1'b0;
                        wbs_stb_o <= 1'b0;
                        wbs_we_o  <= 1'b0;
                        wbm_ack_o <= 1'b1;
                        wbm_dat_o <= w_rd_nx;
                    end else begin
                        wbs_adr_o <= {r_adr, f_addr(w_nlane)};
                        wbs_dat_o <= r_dat[8*w_nlane +: 8];
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/wb_data_resize_seq.md
# wb_data_resize_seq

Sequencing Wishbone width adapter between a 32-bit master port and an 8-bit slave port.
- Converts each master access into back-to-back byte cycles, one per asserted `wbm_sel_i` lane.
- Read bytes are merged into one 32-bit response; the master is acknowledged once, after the last byte.
- Sits between the 32-bit intercon output and narrow peripherals (UART, SPI flash) that need full-word and half-word accesses rather than single-byte only.

## Interface
Parameters:
- `aw`, 32, address width.
- `endian`, "big", byte-lane to address mapping: "big" maps sel[3] to address 0; "little" maps sel[3] to address 3.
- `TIMEOUT`, 255, slave cycles allowed per byte before an error is forced. Used only with the configuration macro.

Ports (the clock is `wb_clk_i`; the reset is `wb_rst_ni`, asynchronous and active-low):
- `wb_clk_i`  in  1  clock
- `wb_rst_ni`  in  1  async active-low reset
- `wbm_adr_i`  in  aw  master address; bits [1:0] ignored
- `wbm_dat_i`  in  32  master write data
- `wbm_sel_i`  in  4  byte lanes
- `wbm_we_i`  in  1  write enable
- `wbm_cyc_i`, `wbm_stb_i`  in  1 each  cycle, strobe
- `wbm_cti_i`  in  3  ignored
- `wbm_bte_i`  in  2  ignored
- `wbm_dat_o`  out  32  merged read data
- `wbm_ack_o`, `wbm_err_o`, `wbm_rty_o`  out  1 each  single-cycle response
- `wbs_adr_o`  out  aw  byte address
- `wbs_dat_o`  out  8  byte write data
- `wbs_we_o`, `wbs_cyc_o`, `wbs_stb_o`  out  1 each
- `wbs_cti_o`  out  3  constant 3'b000
- `wbs_bte_o`  out  2  constant 2'b00
- `wbs_dat_i`  in  8  byte read data
- `wbs_ack_i`, `wbs_err_i`, `wbs_rty_i`  in  1 each

## Operation
- All outputs are registered.
- Reset values: every output is 0, the state is IDLE, and the internal data, address and mask registers are 0.

IDLE
- On `wbm_cyc_i & wbm_stb_i`, capture `adr[aw-1:2]`, `dat`, `sel` and `we`, and clear the read register.
- Pending mask = `sel`.
- If `sel == 0`, go to RESP with ack and data 0, and issue no slave cycle.
- Otherwise go to BUS.

BUS
- `wbs_cyc_o = wbs_stb_o = 1`.
- Current lane = the pending lane with the lowest byte address:
  - "big": lane 3 first, then down to lane 0.
  - "little": lane 0 first, then up to lane 3.
- `wbs_adr_o = {adr[aw-1:2], laneaddr}`, `wbs_dat_o` = that lane's byte, `wbs_we_o = we`.
- On `wbs_ack_i`:
  - On a read, write `wbs_dat_i` into the lane's byte of the read register.
  - Clear the lane bit in the pending mask.
  - If the mask becomes empty, go to RESP(ack).
  - Otherwise stay in BUS; next cycle's address and data move to the next lane, and stb stays high.
- On `wbs_err_i` (priority over ack) or `wbs_rty_i`, abort the remaining lanes and go to RESP(err) or RESP(rty).
- If `wbm_cyc_i` drops: deassert `wbs_cyc_o` and `wbs_stb_o` next cycle, return to IDLE, and give no master response.

RESP
- Exactly one of ack/err/rty is high for one cycle.
- `wbm_dat_o` = read register; unselected lanes read 0. On err or rty it holds the partial data.
- `wbs_cyc_o` and `wbs_stb_o` are 0. Next state is IDLE.

## Timing
- Capture happens in the cycle where IDLE samples stb.
- With a slave that acks in the first cycle stb is seen: k selected lanes → `wbm_ack_o` is high in cycle k+1 after the sample cycle.
- Slave wait states add one cycle each.
- A new master request is accepted no earlier than the cycle after RESP.
- Reset asserted mid-operation clears all outputs immediately, with no response.

## Configuration
- `WB_RESIZE_TIMEOUT_EN` defined:
  - An 8-bit-or-wider counter restarts at each new byte cycle.
  - If it reaches `TIMEOUT` cycles in BUS with no ack, err or rty, the block drops the slave cycle and goes to RESP(err).
- Not defined: no counter exists, BUS waits indefinitely, and `TIMEOUT` is unused.

## Test plan
- Big-endian read, sel=4'b1111, adr=0x100; slave returns 0x11,0x22,0x33,0x44 with immediate ack → slave addresses 0x100–0x103 in order, `wbm_dat_o=0x11223344`, ack in cycle 5.
- Little-endian write, sel=4'b0110, dat=0xAABBCCDD → two slave writes: 0xCC@addr1, then 0xBB@addr2; one master ack.
- sel=4'b0000 → no slave cycle, ack with data 0 in cycle 1.
- Slave err on the second byte of sel=1111 → third and fourth bytes not issued, `wbm_err_o` pulse, first byte kept in `wbm_dat_o`.
- Master drops `wbm_cyc_i` during the second byte → `wbs_cyc_o` low next cycle, no `wbm_ack_o`; the next request completes normally.
- With `WB_RESIZE_TIMEOUT_EN` and TIMEOUT=4, a silent slave → `wbm_err_o` after 4 BUS cycles; without the macro, stb stays high for ≥100 cycles.
